// File: rtl/hilo_muldiv.sv
// hilo_muldiv: multicycle mult/multu/div/divu unit owning HI/LO.
// Ports: clk, rst (async, active-high); start/op/a/b launch an operation;
// hi_we/lo_we/wdata implement mthi/mtlo; busy, done, hi, lo are outputs.
module hilo_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]     cnt;
    logic              is_div;
    logic              neg;      // product / quotient must be negated
    logic              neg_rem;  // remainder takes the sign of a
    logic [XLEN-1:0]   a_raw;    // kept for the divide-by-zero result
    logic [XLEN-1:0]   ma;       // multiplicand, or dividend shifting out
    logic [XLEN-1:0]   mb;       // multiplier shifting out, or divisor
    logic [2*XLEN-1:0] acc;

    logic              sgn_op;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] acc_nxt;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   res_hi;
    logic [XLEN-1:0]   res_lo;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = CALC;
            CALC: if (cnt == CW'(XLEN - 1)) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state != IDLE);
    end

    assign sgn_op = ~op[0];

    // One iteration of shift-add multiply or restoring divide
    always_comb begin
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (mb[0] ? ma : '0)};
        rem_sh  = {acc[2*XLEN-1:XLEN], ma[XLEN-1]};
        diff    = rem_sh - {1'b0, mb};
        acc_nxt = acc;
        if (is_div) begin
            // diff[XLEN] is the borrow: set means divisor did not fit
            if (diff[XLEN])
                acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            else
                acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            acc_nxt = {mul_sum, acc[XLEN-1:1]};
        end
    end

    // Sign correction and special cases
    always_comb begin
        prod_fix = neg ? -acc : acc;
        res_hi   = prod_fix[2*XLEN-1:XLEN];
        res_lo   = prod_fix[XLEN-1:0];
        if (is_div) begin
            if (mb == '0) begin
                res_hi = a_raw;
                res_lo = '1;
            end else begin
                res_lo = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
                res_hi = neg_rem ? -acc[2*XLEN-1:XLEN]
                                 : acc[2*XLEN-1:XLEN];
            end
        end
    end

    // Datapath and HI/LO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            is_div  <= 1'b0;
            neg     <= 1'b0;
            neg_rem <= 1'b0;
            a_raw   <= '0;
            ma      <= '0;
            mb      <= '0;
            acc     <= '0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        is_div  <= op[1];
                        neg     <= sgn_op & (a[XLEN-1] ^ b[XLEN-1]);
                        neg_rem <= sgn_op & a[XLEN-1];
                        a_raw   <= a;
                        ma      <= (sgn_op & a[XLEN-1]) ? -a : a;
                        mb      <= (sgn_op & b[XLEN-1]) ? -b : b;
                        acc     <= '0;
                        cnt     <= '0;
                    end
                end
                CALC: begin
                    cnt <= cnt + CW'(1);
                    acc <= acc_nxt;
                    if (is_div) ma <= {ma[XLEN-2:0], 1'b0};
                    else        mb <= {1'b0, mb[XLEN-1:1]};
                end
                FIX: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: table vectors, random ops against an arithmetic model,
// and hand-written sequences for busy-time inputs and mid-op reset.
module tb_hilo_muldiv;

    localparam int X = 32;

    logic         clk = 0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [X-1:0] a;
    logic [X-1:0] b;
    logic         hi_we;
    logic         lo_we;
    logic [X-1:0] wdata;
    logic         busy;
    logic         done;
    logic [X-1:0] hi;
    logic [X-1:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    hilo_muldiv #(.XLEN(X)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [X-1:0] a;
        logic [X-1:0] b;
        logic [X-1:0] hi;
        logic [X-1:0] lo;
    } vec_t;

    vec_t tbl[6];

    task automatic check(string name, logic [X-1:0] act, logic [X-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the architectural definition
    function automatic logic [2*X-1:0] model(logic [1:0] o, logic [X-1:0] x,
                                             logic [X-1:0] y);
        longint          sp;
        longint unsigned up;
        int              q;
        int              r;
        case (o)
            2'd0: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                return sp;
            end
            2'd1: begin
                up = longint'({32'b0, x}) * longint'({32'b0, y});
                return up;
            end
            2'd2: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                    return {32'h0, 32'h8000_0000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [X-1:0] x,
                          input logic [X-1:0] y, input logic wr,
                          output logic [X-1:0] rhi, output logic [X-1:0] rlo,
                          output int cyc, output int bcnt);
        @(negedge clk);
        start = 1; op = o; a = x; b = y;
        hi_we = wr; lo_we = wr; wdata = 32'hABCD_0123;
        @(negedge clk);
        start = 0; hi_we = 0; lo_we = 0;
        a = $urandom; b = $urandom; op = 2'($urandom);
        cyc = 1;
        bcnt = 0;
        while (!done && cyc < 200) begin
            if (busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
        check("done_seen", {31'b0, done}, 1);
        check("busy_at_done", {31'b0, busy}, 0);
        rhi = hi;
        rlo = lo;
        @(negedge clk);
        check("done_one_cycle", {31'b0, done}, 0);
    endtask

    initial begin
        logic [X-1:0]   rhi;
        logic [X-1:0]   rlo;
        logic [2*X-1:0] exp;
        logic [1:0]     o;
        logic [X-1:0]   x;
        logic [X-1:0]   y;
        int             cyc;
        int             bcnt;
        int             pulses;
        int             sel;

        tbl[0] = '{2'd0, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        tbl[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1};
        tbl[2] = '{2'd2, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[3] = '{2'd3, 32'd100, 32'd7, 32'h2, 32'hE};
        tbl[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000};
        tbl[5] = '{2'd3, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF};

        rst = 1; start = 0; op = 0; a = 0; b = 0;
        hi_we = 0; lo_we = 0; wdata = 0;
        repeat (2) @(negedge clk);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_busy", {31'b0, busy}, 0);
        check("reset_done", {31'b0, done}, 0);
        rst = 0;

        // mthi / mtlo together and separately
        @(negedge clk);
        hi_we = 1; lo_we = 1; wdata = 32'h1111_2222;
        @(negedge clk);
        hi_we = 0; lo_we = 0;
        check("mthi_both", hi, 32'h1111_2222);
        check("mtlo_both", lo, 32'h1111_2222);
        lo_we = 1; wdata = 32'h3333_4444;
        @(negedge clk);
        lo_we = 0;
        check("mtlo_only_hi", hi, 32'h1111_2222);
        check("mtlo_only_lo", lo, 32'h3333_4444);

        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, rhi, rlo, cyc, bcnt);
            check($sformatf("tbl%0d_hi", i), rhi, tbl[i].hi);
            check($sformatf("tbl%0d_lo", i), rlo, tbl[i].lo);
            check($sformatf("tbl%0d_latency", i), cyc, X + 2);
            check($sformatf("tbl%0d_busy_cycles", i), bcnt, X + 1);
        end

        // start with mthi/mtlo in the same cycle: result overwrites
        run_op(2'd1, 32'd2, 32'd3, 1'b1, rhi, rlo, cyc, bcnt);
        check("start_we_hi", rhi, 0);
        check("start_we_lo", rlo, 6);

        // Random ops against the model
        for (int n = 0; n < 60; n++) begin
            o = 2'($urandom);
            x = $urandom;
            y = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) y = 0;
            if (sel == 1) y = $urandom_range(1, 15);
            if (sel == 2) y = -$urandom_range(1, 15);
            if (sel == 3) x = 32'h8000_0000;
            if (sel == 4) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            exp = model(o, x, y);
            run_op(o, x, y, 1'b0, rhi, rlo, cyc, bcnt);
            check($sformatf("rnd%0d_op%0d_hi", n, o), rhi, exp[2*X-1:X]);
            check($sformatf("rnd%0d_op%0d_lo", n, o), rlo, exp[X-1:0]);
        end

        // Inputs while busy are ignored
        @(negedge clk);
        start = 1; op = 2'd0; a = 32'd7; b = 32'hFFFF_FFF7;
        @(negedge clk);
        start = 0;
        repeat (10) @(negedge clk);
        start = 1; op = 2'd3; a = 32'd100; b = 32'd3;
        hi_we = 1; lo_we = 1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 0; hi_we = 0; lo_we = 0;
        check("busy_hi_hold", hi, rhi);
        pulses = 0;
        rhi = 'x;
        rlo = 'x;
        for (int c = 0; c < 80; c++) begin
            if (done) begin
                pulses++;
                rhi = hi;
                rlo = lo;
            end
            @(negedge clk);
        end
        check("busy_ign_pulses", pulses, 1);
        check("busy_ign_hi", rhi, 32'hFFFF_FFFF);
        check("busy_ign_lo", rlo, 32'hFFFF_FFC1);

        // Reset in the middle of a divide
        @(negedge clk);
        start = 1; op = 2'd2; a = 32'd1000; b = 32'd7;
        @(negedge clk);
        start = 0;
        repeat (10) @(negedge clk);
        check("pre_rst_busy", {31'b0, busy}, 1);
        rst = 1;
        #1;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        hi_we = 1; wdata = 32'd5;
        @(negedge clk);
        hi_we = 0;
        check("post_rst_mthi", hi, 32'd5);
        check("post_rst_lo", lo, 0);
        repeat (40) @(negedge clk);
        check("post_rst_no_done", {31'b0, done}, 0);
        check("post_rst_hi_kept", hi, 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
